// File: rtl/urv_dm_wb_bridge.sv
// uRV data-memory to Wishbone classic bridge: IDLE/BUS/RESP FSM, one-entry pending buffer, sticky
// error capture. Define URV_DM_WB_TIMEOUT_EN to build the BUS wait-state timeout counter.
module urv_dm_wb_bridge #(
    parameter int unsigned g_timeout_cycles = 255,
    parameter logic [31:0] g_error_data     = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_error_o,
    output logic [31:0] bus_error_addr_o,
    input  logic        bus_error_clr_i,
    output logic        proto_error_o
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] wb_adr_q, wb_adr_d, wb_dat_q, wb_dat_d, req_addr_q, req_addr_d;
    logic [3:0]  wb_sel_q, wb_sel_d;
    logic        wb_we_q, wb_we_d, wb_cyc_q, wb_cyc_d;
    logic [31:0] dm_data_l_q, dm_data_l_d;
    logic        load_done_q, load_done_d, store_done_q, store_done_d;
    logic        bus_error_q, bus_error_d, proto_error_q, proto_error_d;
    logic [31:0] bus_error_addr_q, bus_error_addr_d;
    logic        pend_valid_q, pend_valid_d, pend_we_q, pend_we_d;
    logic [31:0] pend_addr_q, pend_addr_d, pend_dat_q, pend_dat_d;
    logic [3:0]  pend_sel_q, pend_sel_d;

    logic        req, proto_evt, fail, issue, timeout;
    logic [31:0] iss_addr, iss_dat;
    logic [3:0]  iss_sel;
    logic        iss_we;

    assign req = dm_load_i | dm_store_i;

`ifdef URV_DM_WB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    assign timeout = (state_q == StBus) && (32'(tmo_cnt_q) + 32'd1 == g_timeout_cycles);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        wb_adr_d         = wb_adr_q;
        wb_dat_d         = wb_dat_q;
        wb_sel_d         = wb_sel_q;
        wb_we_d          = wb_we_q;
        wb_cyc_d         = wb_cyc_q;
        req_addr_d       = req_addr_q;
        dm_data_l_d      = dm_data_l_q;
        load_done_d      = 1'b0;
        store_done_d     = 1'b0;
        bus_error_addr_d = bus_error_addr_q;
        pend_valid_d     = pend_valid_q;
        pend_addr_d      = pend_addr_q;
        pend_dat_d       = pend_dat_q;
        pend_sel_d       = pend_sel_q;
        pend_we_d        = pend_we_q;
        proto_evt        = dm_load_i & dm_store_i;
        fail             = 1'b0;
        issue            = 1'b0;
        // A simultaneous load/store resolves to the store.
        iss_addr         = dm_addr_i;
        iss_dat          = dm_data_s_i;
        iss_sel          = dm_data_select_i;
        iss_we           = dm_store_i;
`ifdef URV_DM_WB_TIMEOUT_EN
        tmo_cnt_d        = tmo_cnt_q;
`endif

        unique case (state_q)
            StIdle: issue = req;
            StBus: begin
`ifdef URV_DM_WB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                if (req) begin
                    if (pend_valid_q) begin
                        proto_evt = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = dm_addr_i;
                        pend_dat_d   = dm_data_s_i;
                        pend_sel_d   = dm_data_select_i;
                        pend_we_d    = dm_store_i;
                    end
                end
                if (wb_ack_i || wb_err_i || timeout) begin
                    state_d      = StResp;
                    wb_cyc_d     = 1'b0;
                    fail         = wb_err_i | ~wb_ack_i;
                    load_done_d  = ~wb_we_q;
                    store_done_d = wb_we_q;
                    if (!wb_we_q) dm_data_l_d = fail ? g_error_data : wb_dat_i;
                end
            end
            StResp: begin
                state_d = StIdle;
                if (pend_valid_q) begin
                    issue        = 1'b1;
                    iss_addr     = pend_addr_q;
                    iss_dat      = pend_dat_q;
                    iss_sel      = pend_sel_q;
                    iss_we       = pend_we_q;
                    // The buffered request leaves, so a new pulse can take its slot.
                    pend_valid_d = req;
                    pend_addr_d  = dm_addr_i;
                    pend_dat_d   = dm_data_s_i;
                    pend_sel_d   = dm_data_select_i;
                    pend_we_d    = dm_store_i;
                end else begin
                    issue = req;
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            state_d    = StBus;
            wb_adr_d   = {iss_addr[31:2], 2'b00};
            wb_dat_d   = iss_dat;
            wb_sel_d   = iss_sel;
            wb_we_d    = iss_we;
            wb_cyc_d   = 1'b1;
            req_addr_d = iss_addr;
`ifdef URV_DM_WB_TIMEOUT_EN
            tmo_cnt_d  = 16'd0;
`endif
        end

        if (fail && !bus_error_q) bus_error_addr_d = req_addr_q;
        bus_error_d   = bus_error_clr_i ? 1'b0 : (bus_error_q | fail);
        proto_error_d = bus_error_clr_i ? 1'b0 : (proto_error_q | proto_evt);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= StIdle;
            wb_adr_q         <= '0;
            wb_dat_q         <= '0;
            wb_sel_q         <= '0;
            wb_we_q          <= 1'b0;
            wb_cyc_q         <= 1'b0;
            req_addr_q       <= '0;
            dm_data_l_q      <= '0;
            load_done_q      <= 1'b0;
            store_done_q     <= 1'b0;
            bus_error_q      <= 1'b0;
            bus_error_addr_q <= '0;
            proto_error_q    <= 1'b0;
            pend_valid_q     <= 1'b0;
            pend_addr_q      <= '0;
            pend_dat_q       <= '0;
            pend_sel_q       <= '0;
            pend_we_q        <= 1'b0;
`ifdef URV_DM_WB_TIMEOUT_EN
            tmo_cnt_q        <= '0;
`endif
        end else begin
            state_q          <= state_d;
            wb_adr_q         <= wb_adr_d;
            wb_dat_q         <= wb_dat_d;
            wb_sel_q         <= wb_sel_d;
            wb_we_q          <= wb_we_d;
            wb_cyc_q         <= wb_cyc_d;
            req_addr_q       <= req_addr_d;
            dm_data_l_q      <= dm_data_l_d;
            load_done_q      <= load_done_d;
            store_done_q     <= store_done_d;
            bus_error_q      <= bus_error_d;
            bus_error_addr_q <= bus_error_addr_d;
            proto_error_q    <= proto_error_d;
            pend_valid_q     <= pend_valid_d;
            pend_addr_q      <= pend_addr_d;
            pend_dat_q       <= pend_dat_d;
            pend_sel_q       <= pend_sel_d;
            pend_we_q        <= pend_we_d;
`ifdef URV_DM_WB_TIMEOUT_EN
            tmo_cnt_q        <= tmo_cnt_d;
`endif
        end
    end

    assign wb_adr_o         = wb_adr_q;
    assign wb_dat_o         = wb_dat_q;
    assign wb_sel_o         = wb_sel_q;
    assign wb_we_o          = wb_we_q;
    assign wb_cyc_o         = wb_cyc_q;
    assign wb_stb_o         = wb_cyc_q;
    assign dm_data_l_o      = dm_data_l_q;
    assign dm_load_done_o   = load_done_q;
    assign dm_store_done_o  = store_done_q;
    assign bus_error_o      = bus_error_q;
    assign bus_error_addr_o = bus_error_addr_q;
    assign proto_error_o    = proto_error_q;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Directed self-checking bench for urv_dm_wb_bridge; covers the timeout build when
// URV_DM_WB_TIMEOUT_EN is defined, otherwise the wait-forever build.
module tb_urv_dm_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] dm_addr_i = '0, dm_data_s_i = '0, wb_dat_i = '0;
    logic [3:0]  dm_data_select_i = '0;
    logic        dm_store_i = 1'b0, dm_load_i = 1'b0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, bus_error_clr_i = 1'b0;
    logic [31:0] dm_data_l_o, wb_adr_o, wb_dat_o, bus_error_addr_o;
    logic [3:0]  wb_sel_o;
    logic        dm_load_done_o, dm_store_done_o, wb_cyc_o, wb_stb_o, wb_we_o;
    logic        bus_error_o, proto_error_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

    urv_dm_wb_bridge #(
        .g_timeout_cycles(8),
        .g_error_data    (ErrData)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .dm_addr_i       (dm_addr_i),
        .dm_data_s_i     (dm_data_s_i),
        .dm_data_select_i(dm_data_select_i),
        .dm_store_i      (dm_store_i),
        .dm_load_i       (dm_load_i),
        .dm_data_l_o     (dm_data_l_o),
        .dm_load_done_o  (dm_load_done_o),
        .dm_store_done_o (dm_store_done_o),
        .wb_adr_o        (wb_adr_o),
        .wb_dat_o        (wb_dat_o),
        .wb_sel_o        (wb_sel_o),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_we_o         (wb_we_o),
        .wb_dat_i        (wb_dat_i),
        .wb_ack_i        (wb_ack_i),
        .wb_err_i        (wb_err_i),
        .bus_error_o     (bus_error_o),
        .bus_error_addr_o(bus_error_addr_o),
        .bus_error_clr_i (bus_error_clr_i),
        .proto_error_o   (proto_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic request(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel);
        dm_load_i = ld;
        dm_store_i = st;
        dm_addr_i = addr;
        dm_data_s_i = data;
        dm_data_select_i = sel;
        tick();
        dm_load_i = 1'b0;
        dm_store_i = 1'b0;
    endtask

    task automatic slave_ack(input logic [31:0] data);
        wb_ack_i = 1'b1;
        wb_dat_i = data;
        tick();
        wb_ack_i = 1'b0;
    endtask

    task automatic slave_err();
        wb_err_i = 1'b1;
        tick();
        wb_err_i = 1'b0;
    endtask

    initial begin
        int hi_cycles;
        int stuck;

        #12;
        check_eq("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check_eq("rst_adr", wb_adr_o, 32'd0);
        check_eq("rst_dat_l", dm_data_l_o, 32'd0);
        check_eq("rst_err_addr", bus_error_addr_o, 32'd0);
        check_eq("rst_flags", {28'b0, dm_load_done_o, dm_store_done_o, bus_error_o, proto_error_o},
                 32'd0);
        rst_n_i = 1'b1;
        tick();

        // Zero-wait load.
        request(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF);
        check_eq("ld_cyc", {30'b0, wb_cyc_o, wb_stb_o}, 32'd3);
        check_eq("ld_adr", wb_adr_o, 32'h1000);
        check_eq("ld_we", {31'b0, wb_we_o}, 32'd0);
        slave_ack(32'hCAFE_BABE);
        check_eq("ld_done", {31'b0, dm_load_done_o}, 32'd1);
        check_eq("ld_data", dm_data_l_o, 32'hCAFE_BABE);
        check_eq("ld_cyc_drop", {31'b0, wb_cyc_o}, 32'd0);
        check_eq("ld_no_err", {31'b0, bus_error_o}, 32'd0);
        tick();
        check_eq("ld_done_once", {31'b0, dm_load_done_o}, 32'd0);
        check_eq("ld_data_hold", dm_data_l_o, 32'hCAFE_BABE);

        // Store with 3 wait states.
        request(1'b0, 1'b1, 32'h2002, 32'h00AB_0000, 4'b0100);
        check_eq("st_adr", wb_adr_o, 32'h2000);
        check_eq("st_we_sel", {27'b0, wb_we_o, wb_sel_o}, 32'h14);
        check_eq("st_dat", wb_dat_o, 32'h00AB_0000);
        tick();
        tick();
        tick();
        check_eq("st_wait", {30'b0, wb_cyc_o, dm_store_done_o}, 32'd2);
        slave_ack(32'h0);
        check_eq("st_done", {30'b0, dm_store_done_o, dm_load_done_o}, 32'd2);
        tick();
        check_eq("st_done_once", {31'b0, dm_store_done_o}, 32'd0);

        // Erroring load, then erroring store: first address stays latched.
        request(1'b1, 1'b0, 32'h3000, 32'h0, 4'hF);
        slave_err();
        check_eq("err_ld_done", {31'b0, dm_load_done_o}, 32'd1);
        check_eq("err_ld_data", dm_data_l_o, ErrData);
        check_eq("err_flag", {31'b0, bus_error_o}, 32'd1);
        check_eq("err_addr", bus_error_addr_o, 32'h3000);
        tick();
        request(1'b0, 1'b1, 32'h4000, 32'h1234_5678, 4'hF);
        slave_err();
        check_eq("err_st_done", {31'b0, dm_store_done_o}, 32'd1);
        check_eq("err_addr_keep", bus_error_addr_o, 32'h3000);
        bus_error_clr_i = 1'b1;
        tick();
        bus_error_clr_i = 1'b0;
        check_eq("err_clr", {31'b0, bus_error_o}, 32'd0);

        // Pending buffer: second request queued, third dropped.
        request(1'b1, 1'b0, 32'h5000, 32'h0, 4'hF);
        request(1'b0, 1'b1, 32'h6000, 32'hA5A5_A5A5, 4'h3);
        check_eq("pend_no_proto", {31'b0, proto_error_o}, 32'd0);
        request(1'b1, 1'b0, 32'h7000, 32'h0, 4'hF);
        check_eq("pend_proto", {31'b0, proto_error_o}, 32'd1);
        slave_ack(32'h1111_1111);
        check_eq("pend_first_done", {30'b0, dm_load_done_o, dm_store_done_o}, 32'd2);
        check_eq("pend_first_data", dm_data_l_o, 32'h1111_1111);
        tick();
        check_eq("pend_second_issue", {31'b0, wb_cyc_o}, 32'd1);
        check_eq("pend_second_adr", wb_adr_o, 32'h6000);
        check_eq("pend_second_we", {27'b0, wb_we_o, wb_sel_o}, 32'h13);
        slave_ack(32'h0);
        check_eq("pend_second_done", {30'b0, dm_load_done_o, dm_store_done_o}, 32'd1);
        tick();
        check_eq("pend_third_dropped", {31'b0, wb_cyc_o}, 32'd0);
        bus_error_clr_i = 1'b1;
        tick();
        bus_error_clr_i = 1'b0;
        check_eq("proto_clr", {31'b0, proto_error_o}, 32'd0);

        // Simultaneous load+store, then a request accepted straight from RESP.
        request(1'b1, 1'b1, 32'h8000, 32'h5555_AAAA, 4'hF);
        check_eq("both_we", {31'b0, wb_we_o}, 32'd1);
        check_eq("both_proto", {31'b0, proto_error_o}, 32'd1);
        slave_ack(32'h0);
        check_eq("both_done", {30'b0, dm_load_done_o, dm_store_done_o}, 32'd1);
        request(1'b1, 1'b0, 32'h9000, 32'h0, 4'hF);
        check_eq("resp_accept", {31'b0, wb_cyc_o}, 32'd1);
        check_eq("resp_accept_adr", wb_adr_o, 32'h9000);
        slave_ack(32'h2222_2222);
        check_eq("resp_accept_data", {31'b0, dm_load_done_o}, 32'd1);
        check_eq("resp_accept_val", dm_data_l_o, 32'h2222_2222);
        tick();

        // Silent slave.
        request(1'b1, 1'b0, 32'hA000, 32'h0, 4'hF);
`ifdef URV_DM_WB_TIMEOUT_EN
        hi_cycles = 0;
        while (wb_cyc_o && hi_cycles < 50) begin
            hi_cycles++;
            tick();
        end
        check_eq("tmo_cycles", 32'(hi_cycles), 32'd8);
        check_eq("tmo_done", {31'b0, dm_load_done_o}, 32'd1);
        check_eq("tmo_data", dm_data_l_o, ErrData);
        check_eq("tmo_err", {31'b0, bus_error_o}, 32'd1);
        check_eq("tmo_err_addr", bus_error_addr_o, 32'hA000);
        tick();
        request(1'b1, 1'b0, 32'hB000, 32'h0, 4'hF);
`else
        stuck = 0;
        for (int i = 0; i < 1100; i++) begin
            if (wb_cyc_o) stuck++;
            tick();
        end
        check_eq("no_tmo_hold", 32'(stuck), 32'd1100);
        check_eq("no_tmo_err", {31'b0, bus_error_o}, 32'd0);
`endif

        // Asynchronous reset while in BUS.
        tick();
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("rst_async_cyc", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
        tick();
        rst_n_i = 1'b1;
        hi_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (dm_load_done_o || dm_store_done_o || wb_cyc_o) hi_cycles++;
            tick();
        end
        check_eq("rst_quiet", 32'(hi_cycles), 32'd0);
        request(1'b1, 1'b0, 32'hC000, 32'h0, 4'hF);
        check_eq("post_rst_adr", wb_adr_o, 32'hC000);
        slave_ack(32'h3333_4444);
        check_eq("post_rst_done", {31'b0, dm_load_done_o}, 32'd1);
        check_eq("post_rst_data", dm_data_l_o, 32'h3333_4444);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
